// File: rtl/int_controller.sv
// Edge-triggered 8-source interrupt controller with mask and pending registers on the MCU IO bus.
// Optional INT_CONTROLLER_SYNC_EN adds a 2-flop synchronizer on every source input.
module int_controller #(
    parameter logic [7:0] MASK_PORT = 8'h40,
    parameter logic [7:0] PEND_PORT = 8'h41,
    parameter logic [7:0] ID_PORT   = 8'h42
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] INT_SRC,
    input  logic       IO_STRB,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    output logic [7:0] IN_DATA,
    output logic       INT_R,
    input  logic       INT_ACK,
    input  logic       INT_DONE,
    output logic [2:0] INT_ID
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    state_t     state_q;
    logic       int_r_q;
    logic [2:0] int_id_q;
    logic [7:0] mask_q, mask_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] prev_q;
    logic [7:0] src;
    logic [7:0] rise;
    logic [7:0] elig;
    logic [2:0] low_idx;
    logic       ack_clr;

`ifdef INT_CONTROLLER_SYNC_EN
    logic [7:0] sync1_q, sync2_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= INT_SRC;
            sync2_q <= sync1_q;
        end
    end

    assign src = sync2_q;
`else
    assign src = INT_SRC;
`endif

    assign rise    = src & ~prev_q;
    assign elig    = pend_q & mask_q;
    assign ack_clr = (state_q == S_REQ) && INT_ACK;

    always_comb begin
        logic found;
        found   = 1'b0;
        low_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (elig[i] && !found) begin
                found   = 1'b1;
                low_idx = 3'(i);
            end
        end
    end

    // A fresh edge is OR'ed in last so it survives a same-cycle software clear or ack.
    always_comb begin
        mask_d = mask_q;
        pend_d = pend_q;
        if (IO_STRB && (PORT_ID == MASK_PORT))
            mask_d = OUT_PORT;
        if (IO_STRB && (PORT_ID == PEND_PORT))
            pend_d = pend_d & ~OUT_PORT;
        if (ack_clr)
            pend_d[int_id_q] = 1'b0;
        pend_d = pend_d | rise;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_q <= '0;
            mask_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= src;
            mask_q <= mask_d;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            int_r_q  <= 1'b0;
            int_id_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (elig != '0) begin
                        state_q  <= S_REQ;
                        int_r_q  <= 1'b1;
                        int_id_q <= low_idx;
                    end
                end
                S_REQ: begin
                    if (INT_ACK) begin
                        state_q <= S_SERVICE;
                        int_r_q <= 1'b0;
                    end else if (!elig[int_id_q]) begin
                        state_q <= S_IDLE;
                        int_r_q <= 1'b0;
                    end
                end
                S_SERVICE: begin
                    if (INT_DONE) begin
                        state_q <= S_IDLE;
                        int_r_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    int_r_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        IN_DATA = '0;
        if (PORT_ID == MASK_PORT)
            IN_DATA = mask_q;
        else if (PORT_ID == PEND_PORT)
            IN_DATA = pend_q;
        else if (PORT_ID == ID_PORT)
            IN_DATA = {5'b0, int_id_q};
    end

    assign INT_R  = int_r_q;
    assign INT_ID = int_id_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed-vector bench for int_controller: register access, priority, withdrawal and async reset.
module tb_int_controller;

    logic       CLK;
    logic       RESET;
    logic [7:0] INT_SRC;
    logic       IO_STRB;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic [7:0] IN_DATA;
    logic       INT_R;
    logic       INT_ACK;
    logic       INT_DONE;
    logic [2:0] INT_ID;

    int checks = 0;
    int errors = 0;

    int_controller #(
        .MASK_PORT(8'h40),
        .PEND_PORT(8'h41),
        .ID_PORT  (8'h42)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .INT_SRC (INT_SRC),
        .IO_STRB (IO_STRB),
        .PORT_ID (PORT_ID),
        .OUT_PORT(OUT_PORT),
        .IN_DATA (IN_DATA),
        .INT_R   (INT_R),
        .INT_ACK (INT_ACK),
        .INT_DONE(INT_DONE),
        .INT_ID  (INT_ID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       strb;
        logic [7:0] port;
        logic [7:0] data;
        logic [7:0] src;
        logic       ack;
        logic       done;
        logic [7:0] exp_in;
        logic       exp_r;
        logic [2:0] exp_id;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic strb, input logic [7:0] port, input logic [7:0] data,
                         input logic [7:0] src, input logic ack, input logic done);
        IO_STRB  = strb;
        PORT_ID  = port;
        OUT_PORT = data;
        INT_SRC  = src;
        INT_ACK  = ack;
        INT_DONE = done;
    endtask

    task automatic read(input string name, input logic [7:0] port, input logic [7:0] exp);
        PORT_ID = port;
        #1;
        check(name, IN_DATA, exp);
    endtask

    initial begin
        // strb port data src ack done | in_data int_r int_id
        // mask 01, pulse src0, ack, done
        vecs[0]  = '{1'b1, 8'h40, 8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 3'd0};
        vecs[1]  = '{1'b0, 8'h41, 8'h00, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 3'd0};
        vecs[2]  = '{1'b0, 8'h41, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0};
        vecs[3]  = '{1'b0, 8'h41, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0};
        vecs[4]  = '{1'b0, 8'h42, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0};
        vecs[5]  = '{1'b0, 8'h41, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0};
        vecs[6]  = '{1'b0, 8'h41, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0};
        // masked source accumulates, unmask raises request
        vecs[7]  = '{1'b1, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0};
        vecs[8]  = '{1'b0, 8'h41, 8'h00, 8'h08, 1'b0, 1'b0, 8'h08, 1'b0, 3'd0};
        vecs[9]  = '{1'b0, 8'h41, 8'h00, 8'h00, 1'b0, 1'b0, 8'h08, 1'b0, 3'd0};
        vecs[10] = '{1'b1, 8'h40, 8'h08, 8'h00, 1'b0, 1'b0, 8'h08, 1'b0, 3'd0};
        vecs[11] = '{1'b0, 8'h41, 8'h00, 8'h00, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3};
        vecs[12] = '{1'b0, 8'h42, 8'h00, 8'h00, 1'b1, 1'b0, 8'h03, 1'b0, 3'd3};
        vecs[13] = '{1'b0, 8'h41, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd3};
        // request for id 4 withdrawn by masking, then W1C
        vecs[14] = '{1'b1, 8'h40, 8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 3'd3};
        vecs[15] = '{1'b0, 8'h41, 8'h00, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 3'd3};
        vecs[16] = '{1'b0, 8'h41, 8'h00, 8'h00, 1'b0, 1'b0, 8'h10, 1'b1, 3'd4};
        vecs[17] = '{1'b1, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 3'd4};
        vecs[18] = '{1'b0, 8'h41, 8'h00, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0, 3'd4};
        vecs[19] = '{1'b1, 8'h41, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd4};
        vecs[20] = '{1'b0, 8'h41, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd4};
        // same-cycle edge beats W1C clear; next clear succeeds; unmapped port reads 0
        vecs[21] = '{1'b1, 8'h41, 8'h04, 8'h04, 1'b0, 1'b0, 8'h04, 1'b0, 3'd4};
        vecs[22] = '{1'b1, 8'h41, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd4};

        RESET = 1'b1;
        drive(1'b0, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        check("rst_int_r", {7'b0, INT_R}, 8'h00);
        check("rst_int_id", {5'b0, INT_ID}, 8'h00);
        read("rst_mask", 8'h40, 8'h00);
        read("rst_pend", 8'h41, 8'h00);
        @(negedge CLK);
        RESET = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].strb, vecs[i].port, vecs[i].data, vecs[i].src, vecs[i].ack, vecs[i].done);
            tick();
            check($sformatf("v%0d_in_data", i), IN_DATA, vecs[i].exp_in);
            check($sformatf("v%0d_int_r", i), {7'b0, INT_R}, {7'b0, vecs[i].exp_r});
            check($sformatf("v%0d_int_id", i), {5'b0, INT_ID}, {5'b0, vecs[i].exp_id});
        end
        read("unmapped_port", 8'h7E, 8'h00);

        // Simultaneous edges on 5 and 2: 2 first, 5 after one idle cycle
        drive(1'b1, 8'h40, 8'hFF, 8'h00, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h41, 8'h00, 8'h24, 1'b0, 1'b0);
        tick();
        check("prio_pend", IN_DATA, 8'h24);
        check("prio_r0", {7'b0, INT_R}, 8'h00);
        drive(1'b0, 8'h41, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        check("prio_r1", {7'b0, INT_R}, 8'h01);
        check("prio_id2", {5'b0, INT_ID}, 8'h02);
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
        check("prio_ack_pend", IN_DATA, 8'h20);
        check("prio_ack_r", {7'b0, INT_R}, 8'h00);
        INT_DONE = 1'b1;
        tick();
        INT_DONE = 1'b0;
        check("b2b_idle_r", {7'b0, INT_R}, 8'h00);
        tick();
        check("b2b_req_r", {7'b0, INT_R}, 8'h01);
        check("b2b_id5", {5'b0, INT_ID}, 8'h05);
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
        INT_DONE = 1'b1;
        tick();
        INT_DONE = 1'b0;
        check("b2b_done_pend", IN_DATA, 8'h00);

        // Reset asynchronously while servicing id 1 with id 2 still pending
        INT_SRC = 8'h06;
        tick();
        INT_SRC = 8'h00;
        tick();
        check("svc_id1", {5'b0, INT_ID}, 8'h01);
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
        check("svc_pend", IN_DATA, 8'h04);
        #2;
        RESET = 1'b1;
        INT_SRC = 8'h08;
        #1;
        check("arst_int_r", {7'b0, INT_R}, 8'h00);
        check("arst_int_id", {5'b0, INT_ID}, 8'h00);
        read("arst_mask", 8'h40, 8'h00);
        read("arst_pend", 8'h41, 8'h00);
        @(negedge CLK);
        RESET = 1'b0;
        INT_DONE = 1'b1;
        tick();
        INT_DONE = 1'b0;
        // Source held high across reset release registers exactly one event
        check("rel_pend", IN_DATA, 8'h08);
        check("rel_int_r", {7'b0, INT_R}, 8'h00);
        tick();
        check("rel_pend_hold", IN_DATA, 8'h08);
        check("rel_int_r2", {7'b0, INT_R}, 8'h00);
        INT_SRC = 8'h00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
